fullyconnected_controller: RTL

Sequential scheduler and datapath for the final fully connected layer. It replaces the single-cycle, all-parallel dot product with a one-MAC-per-cycle datapath. On a start pulse it walks the flattened feature-map buffer and the FC weight buffer by address, accumulates the products, adds the bias once, saturates the sum to DATA_WIDTH, and reports the result with a done pulse. It sits between the CNN top-level sequencer (start/done) and the flatten/weight storage (read ports).

---
 rtl/fc_pkg.sv | 33 +++
 rtl/fc_mac_unit.sv | 52 +++++
 rtl/fullyconnected_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types, default widths and the saturation helper for the fully connected layer.
package fc_pkg;

  localparam int unsigned FC_FLATTENED_LENGTH = 432;
  localparam int unsigned FC_DATA_WIDTH       = 8;
  localparam int unsigned FC_ACC_WIDTH        = 32;
  localparam int unsigned SAT_WIDTH           = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } fc_state_e;

  // Clamp a wide signed value into the signed range of a w-bit result.
  function automatic logic signed [SAT_WIDTH-1:0] saturate(
    input logic signed [SAT_WIDTH-1:0] x,
    input int unsigned                 w
  );
    logic signed [SAT_WIDTH-1:0] hi;
    logic signed [SAT_WIDTH-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Registered signed multiply-accumulate with a bias-add and saturating result register.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FC_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = FC_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic                         load,
  input  logic signed [DATA_WIDTH-1:0] feature,
  input  logic signed [DATA_WIDTH-1:0] weight,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [SAT_WIDTH-1:0]    biased;

  assign prod = feature * weight;

  // The result is loaded from the same sum that closes the accumulation, so the
  // last product and the bias land in one cycle.
  always_comb begin
    acc_sum = acc_q;
    if (en) begin
      acc_sum = acc_q + ACC_WIDTH'(prod);
    end
    biased = SAT_WIDTH'(acc_sum) + SAT_WIDTH'(bias);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      result <= '0;
    end else begin
      if (clear) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_sum;
      end
      if (load) begin
        result <= DATA_WIDTH'(saturate(biased, DATA_WIDTH));
      end
    end
  end

endmodule

// File: rtl/fullyconnected_controller.sv
// One-MAC-per-cycle scheduler for the final fully connected layer: walks the
// feature/weight buffers by address, accumulates, adds bias and saturates.
module fullyconnected_controller
  import fc_pkg::*;
#(
  parameter int unsigned FLATTENED_LENGTH          = FC_FLATTENED_LENGTH,
  parameter int unsigned DATA_WIDTH                = FC_DATA_WIDTH,
  parameter int unsigned FULLYCONNECTED_DATA_WIDTH = FC_ACC_WIDTH,
  parameter int unsigned ADDR_WIDTH =
    (FLATTENED_LENGTH > 1) ? $clog2(FLATTENED_LENGTH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fullyconnect_start,
  output logic                         fullyconnect_busy,
  output logic                         fullyconnect_done,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic signed [DATA_WIDTH-1:0] feature_data,
  input  logic signed [DATA_WIDTH-1:0] weight_data,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] fullyconnected_output
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FLATTENED_LENGTH - 1);

  fc_state_e             state_q;
  fc_state_e             state_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  mac_clear_c;
  logic                  mac_load_c;
  logic                  data_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fullyconnect_start) state_d = FETCH;
      FETCH:   if (rd_addr == LAST_ADDR) state_d = DRAIN;
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    rd_en_d     = (state_d == FETCH);
    addr_d      = rd_addr;
    mac_clear_c = 1'b0;
    mac_load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fullyconnect_start) begin
          mac_clear_c = 1'b1;
          addr_d      = '0;
        end
      end
      FETCH: begin
        if (rd_addr != LAST_ADDR) begin
          addr_d = rd_addr + ADDR_WIDTH'(1);
        end
      end
      DRAIN:   mac_load_c = 1'b1;
      default: ;
    endcase
  end

  // Read data is valid one cycle after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fullyconnect_busy <= 1'b0;
      fullyconnect_done <= 1'b0;
      rd_en             <= 1'b0;
      rd_addr           <= '0;
      data_valid_q      <= 1'b0;
    end else begin
      fullyconnect_busy <= busy_d;
      fullyconnect_done <= done_d;
      rd_en             <= rd_en_d;
      rd_addr           <= addr_d;
      data_valid_q      <= rd_en;
    end
  end

  fc_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (FULLYCONNECTED_DATA_WIDTH)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (mac_clear_c),
    .en      (data_valid_q),
    .load    (mac_load_c),
    .feature (feature_data),
    .weight  (weight_data),
    .bias    (bias),
    .result  (fullyconnected_output)
  );

endmodule
